shift_rows_pipe: RTL
====================

Name: shift_rows_pipe

Overview:
- Parametrised Rijndael ShiftRows / InvShiftRows unit for block widths of 128, 192 and 256 bits (NB = 4, 6 or 8 columns).
- The transform direction is selected per beat by a mode bit.
- Results are buffered in a DEPTH-entry output FIFO behind a valid/ready handshake.
- Sits between the SubBytes/InvSubBytes stage and the MixColumns/AddRoundKey stage of the round datapath. It replaces fixed combinational shift blocks when rounds are streamed.

Parameters:
- NB, 4, state columns; legal values 4, 6, 8; state width W = 32*NB.
- DEPTH, 2, output FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  unit can accept a beat.
- in_mode  input  1  0 = ShiftRows (forward), 1 = InvShiftRows.
- in_data  input  W  state in.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  W  transformed state.
- out_mode  output  1  mode carried with the beat.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Byte map: s[r][c] occupies bits [W-1-8*(4c+r) -: 8]. Byte s[0][0] is the MSB byte; a column is 4 consecutive bytes.
- Row offsets Cr:
  - Row 0: 0.
  - Row 1: 1.
  - Row 2: 2 for NB = 4 or 6; 3 for NB = 8.
  - Row 3: 3 for NB = 4 or 6; 4 for NB = 8.
- Forward: s'[r][c] = s[r][(c+Cr) mod NB].
- Inverse: s'[r][c] = s[r][(c-Cr+NB) mod NB].
- The permutation is pure wiring; it is applied on the write side of the FIFO.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (count != DEPTH). It depends only on registered state, with no combinational path from out_ready.
- When full, a pop in cycle N frees a slot; in_ready rises in cycle N+1.
- Latency: a beat pushed at edge N is on out_data with out_valid=1 after that edge. With an empty FIFO, results appear 1 cycle after the push.
- Simultaneous push and pop: count unchanged; both pointers advance. This is legal at any count in 1..DEPTH-1.
- Push when empty with out_ready=1 in the same cycle: no pop, because out_valid=0 that cycle.
- out_data, out_mode and out_valid are held stable while out_valid && !out_ready.
- Pointers are log2(DEPTH)-bit and wrap naturally. Full/empty are derived from count.
- Order is strictly FIFO; modes may be mixed freely between beats.
- Reset values: count=0, pointers=0, out_valid=0, in_ready=0 while rst_n=0 and 1 from the first edge after release, out_data=0, out_mode=0.
- Reset mid-stream discards all stored beats immediately (asynchronous). No partial output survives.
- NB values other than 4, 6 or 8, or DEPTH not a power of two: elaboration-time $error.

Optional Feature:
- Macro: SHIFT_ROWS_PARITY_EN.
- Defined:
  - Adds in_par (input, 4*NB), out_par (output, 4*NB) and par_err (output, 1).
  - Parity bit i is even parity of byte i in the same byte order as data (bit 4*NB-1 = s[0][0]).
  - out_par is permuted identically to data and stored in the FIFO.
  - par_err is sticky. It is set on the edge after any pushed beat whose in_par mismatches in_data, and cleared only by reset (reset value 0).
  - Mismatched beats are still pushed unchanged.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package aes_pkg holds:
  - MODE_FWD=1'b0 and MODE_INV=1'b1.
  - Function shift_off(nb, row) returning Cr.
  - Function state_bytes(nb) = 4*nb.
- Sub-module shift_rows_perm (parameter NB; inputs mode and din; output dout) is purely combinational and instantiated once on the write side. It is reusable by the key-expansion path.

Test Plan:
- Forward, NB=4: push 128'hd42711aee0bf98f1b8b45de51e415230 with mode=0 and out_ready=1 -> next cycle out_data=128'hd4bf5d30e0b452aeb84111f11e2798e5, out_mode=0.
- Inverse, NB=4: push 128'hd4bf5d30e0b452aeb84111f11e2798e5 with mode=1 -> out_data=128'hd42711aee0bf98f1b8b45de51e415230.
- Round-trip, NB=6 and NB=8: 200 random states; feed each output back with the opposite mode -> original recovered. For NB=8, row 2 offset 3 checked on input bytes 00..1f (s[2][0] out = byte at column 3).
- Back-pressure, DEPTH=4: hold out_ready=0 and push 5 beats (values 1..5) -> in_ready=0 after the 4th push, count=4. Release out_ready -> outputs arrive in order 1..4; the 5th beat is accepted one cycle after the first pop; no loss or duplication.
- Reset mid-stream: count=3, assert rst_n=0 for 1 cycle -> out_valid=0 and count=0 immediately; the first beat after release is output correctly.
- With SHIFT_ROWS_PARITY_EN: push a beat with parity bit for byte s[1][2] flipped -> par_err=1 on the next edge and stays 1 through 10 good beats. out_par equals the permuted in_par.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared Rijndael constants and helpers for the ShiftRows round stage.
// Also used by the key-expansion path for row offset lookup.
package aes_pkg;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    // Row offset Cr; the wide 256-bit block moves rows 2 and 3 one column further.
    function automatic int unsigned shift_off(input int unsigned nb, input int unsigned row);
        int unsigned off;
        off = 0;
        case (row)
            1:       off = 1;
            2:       off = (nb == 8) ? 3 : 2;
            3:       off = (nb == 8) ? 4 : 3;
            default: off = 0;
        endcase
        return off;
    endfunction

    function automatic int unsigned state_bytes(input int unsigned nb);
        return 4 * nb;
    endfunction

    // Source column feeding output column col of the given row.
    function automatic int unsigned src_col(input int unsigned nb, input int unsigned row,
                                            input int unsigned col, input logic mode);
        int unsigned off;
        off = shift_off(nb, row);
        if (mode == MODE_INV) begin
            return (col + nb - off) % nb;
        end
        return (col + off) % nb;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for NB = 4, 6 or 8 columns.
// Pure wiring plus one 2:1 mux per byte selected by mode.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic              mode,
    input  logic [32*NB-1:0]  din,
    output logic [32*NB-1:0]  dout
);

    localparam int unsigned W = 32 * NB;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int unsigned FwdC = src_col(NB, r, c, MODE_FWD);
            localparam int unsigned InvC = src_col(NB, r, c, MODE_INV);
            assign dout[W-1-8*(4*c+r) -: 8] = (mode == MODE_INV) ?
                                              din[W-1-8*(4*InvC+r) -: 8] :
                                              din[W-1-8*(4*FwdC+r) -: 8];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// Streaming ShiftRows / InvShiftRows stage: permutation on the write side of a DEPTH-entry FIFO.
// Optional per-byte parity carry and sticky error flag under SHIFT_ROWS_PARITY_EN.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic [32*NB-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [32*NB-1:0]         out_data,
    output logic                     out_mode,
    output logic [$clog2(DEPTH):0]   count
`ifdef SHIFT_ROWS_PARITY_EN
    ,
    input  logic [4*NB-1:0]          in_par,
    output logic [4*NB-1:0]          out_par,
    output logic                     par_err
`endif
);

    localparam int unsigned W   = 32 * NB;
    localparam int unsigned NBY = state_bytes(NB);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("shift_rows_pipe: DEPTH must be a power of two >= 2");
    end

    logic [W-1:0]  perm_data;
    logic [W-1:0]  data_mem_q [DEPTH];
    logic [W-1:0]  data_mem_d [DEPTH];
    logic          mode_mem_q [DEPTH];
    logic          mode_mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rdy_q, rdy_d;
    logic          push, pop;

    shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .mode (in_mode),
        .din  (in_data),
        .dout (perm_data)
    );

    // in_ready stays low during reset and only looks at registered state.
    assign in_ready  = rdy_q && (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        data_mem_d = data_mem_q;
        mode_mem_d = mode_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rdy_d      = 1'b1;
        if (push) begin
            data_mem_d[wr_ptr_q] = perm_data;
            mode_mem_d[wr_ptr_q] = in_mode;
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_mem_q <= '{default: '0};
            mode_mem_q <= '{default: 1'b0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rdy_q      <= 1'b0;
        end else begin
            data_mem_q <= data_mem_d;
            mode_mem_q <= mode_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rdy_q      <= rdy_d;
        end
    end

    always_comb begin
        out_data = '0;
        out_mode = 1'b0;
        if (out_valid) begin
            out_data = data_mem_q[rd_ptr_q];
            out_mode = mode_mem_q[rd_ptr_q];
        end
    end

`ifdef SHIFT_ROWS_PARITY_EN
    logic [NBY-1:0] perm_par;
    logic [NBY-1:0] par_bad;
    logic [NBY-1:0] par_mem_q [DEPTH];
    logic [NBY-1:0] par_mem_d [DEPTH];
    logic           par_err_q, par_err_d;

    // Parity bits follow their bytes through the same permutation.
    for (genvar r = 0; r < 4; r++) begin : g_prow
        for (genvar c = 0; c < NB; c++) begin : g_pcol
            localparam int unsigned FwdC = src_col(NB, r, c, MODE_FWD);
            localparam int unsigned InvC = src_col(NB, r, c, MODE_INV);
            assign perm_par[NBY-1-(4*c+r)] = (in_mode == MODE_INV) ?
                                             in_par[NBY-1-(4*InvC+r)] :
                                             in_par[NBY-1-(4*FwdC+r)];
        end
    end

    for (genvar i = 0; i < NBY; i++) begin : g_pchk
        assign par_bad[NBY-1-i] = in_par[NBY-1-i] ^ (^in_data[W-1-8*i -: 8]);
    end

    always_comb begin
        par_mem_d = par_mem_q;
        if (push) begin
            par_mem_d[wr_ptr_q] = perm_par;
        end
        par_err_d = par_err_q | (push & (|par_bad));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_mem_q <= '{default: '0};
            par_err_q <= 1'b0;
        end else begin
            par_mem_q <= par_mem_d;
            par_err_q <= par_err_d;
        end
    end

    assign out_par = out_valid ? par_mem_q[rd_ptr_q] : '0;
    assign par_err = par_err_q;
`endif

endmodule
